// File: rtl/bp_be_hazard_tracker_pkg.sv
// Shared types and default parameters for the BE issue-stage hazard tracker.
// Optional feature macro used by the tracker: BP_BE_HAZARD_TRACKER_PERF_EN.
package bp_be_pkg;

  localparam int bp_be_depth_gp      = 4;
  localparam int bp_be_num_pipes_gp  = 6;
  localparam int bp_be_num_rf_gp     = 2;
  localparam int bp_be_num_rs_gp     = 3;
  localparam int bp_be_reg_addr_w_gp = 5;
  localparam int bp_be_rf_sel_w_gp   = (bp_be_num_rf_gp > 1) ? $clog2(bp_be_num_rf_gp) : 1;

  // Pipe p's forwarding latency lives in nibble p (pipe 0 in the low nibble).
  localparam logic [4*bp_be_num_pipes_gp-1:0] bp_be_ready_stage_gp =
    {4'd5, 4'd3, 4'd3, 4'd2, 4'd1, 4'd1};

  typedef enum logic [1:0] {
    e_haz_data_bit   = 2'd0,
    e_haz_sb_bit     = 2'd1,
    e_haz_ctrl_bit   = 2'd2,
    e_haz_struct_bit = 2'd3
  } bp_be_haz_cause_e;

  typedef enum logic {
    e_fence_idle  = 1'b0,
    e_fence_drain = 1'b1
  } bp_be_fence_state_e;

  typedef struct packed {
    logic                           v;
    logic [bp_be_num_pipes_gp-1:0]  pipe;
    logic                           rd_w;
    logic [bp_be_rf_sel_w_gp-1:0]   rf;
    logic [bp_be_reg_addr_w_gp-1:0] rd;
    logic                           mem;
  } bp_be_haz_dep_entry_s;

endpackage

// File: rtl/bp_be_hazard_tracker_scoreboard.sv
// One register file's busy-bit scoreboard for long-latency writers, with
// num_rs_p source read ports plus a destination (WAW) read port.
module bp_be_hazard_scoreboard #(
  parameter int num_rs_p         = 3,
  parameter int reg_addr_width_p = 5,
  parameter bit zero_reg_p       = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 set_v_i,
  input  logic [reg_addr_width_p-1:0]          set_addr_i,
  input  logic                                 clr_v_i,
  input  logic [reg_addr_width_p-1:0]          clr_addr_i,
  input  logic [num_rs_p-1:0]                  rs_v_i,
  input  logic [num_rs_p*reg_addr_width_p-1:0] rs_addr_i,
  input  logic                                 rd_v_i,
  input  logic [reg_addr_width_p-1:0]          rd_addr_i,
  output logic                                 hit_o
);

  localparam int num_regs_lp = 1 << reg_addr_width_p;

  logic [num_regs_lp-1:0] busy_q, busy_d, visible;

  // Set is applied after clear so a same-cycle set/clear of one register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_v_i) busy_d[clr_addr_i] = 1'b0;
    if (set_v_i) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign visible = zero_reg_p ? {busy_q[num_regs_lp-1:1], 1'b0} : busy_q;

  always_comb begin
    hit_o = rd_v_i & visible[rd_addr_i];
    for (int s = 0; s < num_rs_p; s++) begin
      hit_o = hit_o | (rs_v_i[s] & visible[rs_addr_i[s*reg_addr_width_p +: reg_addr_width_p]]);
    end
  end

endmodule

// File: rtl/bp_be_hazard_tracker.sv
// Issue-stage hazard tracker: dependency shift register, late-writer scoreboards,
// fence-drain FSM. Optional macro BP_BE_HAZARD_TRACKER_PERF_EN adds stall counters.
module bp_be_hazard_tracker
  import bp_be_pkg::*;
#(
  parameter int                          depth_p          = bp_be_depth_gp,
  parameter int                          num_pipes_p      = bp_be_num_pipes_gp,
  parameter logic [4*num_pipes_p-1:0]    ready_stage_p    = bp_be_ready_stage_gp,
  parameter int                          num_rf_p         = bp_be_num_rf_gp,
  parameter int                          num_rs_p         = bp_be_num_rs_gp,
  parameter int                          reg_addr_width_p = bp_be_reg_addr_w_gp,
  parameter int                          rf_sel_w         = (num_rf_p > 1) ? $clog2(num_rf_p) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 freeze_i,
  input  logic [num_rs_p-1:0]                  issue_rs_v_i,
  input  logic [num_rs_p*rf_sel_w-1:0]         issue_rs_rf_i,
  input  logic [num_rs_p*reg_addr_width_p-1:0] issue_rs_addr_i,
  input  logic                                 issue_rd_v_i,
  input  logic [rf_sel_w-1:0]                  issue_rd_rf_i,
  input  logic [reg_addr_width_p-1:0]          issue_rd_addr_i,
  input  logic                                 issue_fence_i,
  input  logic                                 issue_mem_i,
  input  logic                                 issue_long_i,
  input  logic                                 dispatch_v_i,
  input  logic [num_pipes_p-1:0]               dispatch_pipe_i,
  input  logic                                 dispatch_rd_w_i,
  input  logic                                 dispatch_late_i,
  input  logic                                 dispatch_mem_i,
  input  logic [rf_sel_w-1:0]                  dispatch_rd_rf_i,
  input  logic [reg_addr_width_p-1:0]          dispatch_rd_addr_i,
  input  logic [num_rf_p-1:0]                  clear_v_i,
  input  logic [num_rf_p*reg_addr_width_p-1:0] clear_addr_i,
  input  logic                                 credits_empty_i,
  input  logic                                 mem_ready_i,
  input  logic                                 long_ready_i,
  output logic                                 dispatch_ok_o,
  output logic [3:0]                           haz_cause_o,
  output logic                                 drain_o
`ifdef BP_BE_HAZARD_TRACKER_PERF_EN
  ,
  output logic [4*32-1:0]                      stall_cnt_o
`endif
);

  function automatic logic [3:0] pipe_ready(input logic [num_pipes_p-1:0] pipe);
    logic [3:0] r;
    r = '0;
    for (int p = 0; p < num_pipes_p; p++) begin
      if (pipe[p]) r = r | ready_stage_p[4*p +: 4];
    end
    return r;
  endfunction

  // Dependency shift register; dep_q[0] holds the instruction dispatched last cycle.
  bp_be_haz_dep_entry_s dep_q [depth_p];
  bp_be_haz_dep_entry_s dep_in;

  always_comb begin
    dep_in = '0;
    if (dispatch_v_i) begin
      dep_in.v    = 1'b1;
      dep_in.pipe = dispatch_pipe_i;
      dep_in.rd_w = dispatch_rd_w_i;
      dep_in.rf   = dispatch_rd_rf_i;
      dep_in.rd   = dispatch_rd_addr_i;
      dep_in.mem  = dispatch_mem_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < depth_p; i++) dep_q[i] <= '0;
    end else begin
      dep_q[0] <= dep_in;
      for (int i = 1; i < depth_p; i++) dep_q[i] <= dep_q[i-1];
    end
  end

  logic [rf_sel_w-1:0]         rs_rf   [num_rs_p];
  logic [reg_addr_width_p-1:0] rs_addr [num_rs_p];
  logic [num_rs_p-1:0]         rs_zero;

  for (genvar s = 0; s < num_rs_p; s++) begin : g_src
    assign rs_rf[s]   = issue_rs_rf_i[s*rf_sel_w +: rf_sel_w];
    assign rs_addr[s] = issue_rs_addr_i[s*reg_addr_width_p +: reg_addr_width_p];
    assign rs_zero[s] = (rs_rf[s] == '0) && (rs_addr[s] == '0);
  end

  // A writer blocks a reader only until its pipe's result reaches the bypass network.
  logic data_haz;
  always_comb begin
    data_haz = 1'b0;
    for (int s = 0; s < num_rs_p; s++) begin
      for (int i = 0; i < depth_p; i++) begin
        if (issue_rs_v_i[s] && !rs_zero[s] && dep_q[i].v && dep_q[i].rd_w
            && (dep_q[i].rf == rs_rf[s]) && (dep_q[i].rd == rs_addr[s])
            && ((i + 1) < int'(pipe_ready(dep_q[i].pipe)))) begin
          data_haz = 1'b1;
        end
      end
    end
  end

  logic                sb_set;
  logic [num_rf_p-1:0] sb_hit;

  assign sb_set = dispatch_v_i & dispatch_late_i & dispatch_rd_w_i;

  for (genvar r = 0; r < num_rf_p; r++) begin : g_sb
    logic [num_rs_p-1:0] rs_v;
    for (genvar s = 0; s < num_rs_p; s++) begin : g_rs
      assign rs_v[s] = issue_rs_v_i[s] & (rs_rf[s] == rf_sel_w'(r));
    end

    bp_be_hazard_scoreboard #(
      .num_rs_p         (num_rs_p),
      .reg_addr_width_p (reg_addr_width_p),
      .zero_reg_p       (r == 0)
    ) u_sb (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .set_v_i    (sb_set & (dispatch_rd_rf_i == rf_sel_w'(r))),
      .set_addr_i (dispatch_rd_addr_i),
      .clr_v_i    (clear_v_i[r]),
      .clr_addr_i (clear_addr_i[r*reg_addr_width_p +: reg_addr_width_p]),
      .rs_v_i     (rs_v),
      .rs_addr_i  (issue_rs_addr_i),
      .rd_v_i     (issue_rd_v_i & (issue_rd_rf_i == rf_sel_w'(r))),
      .rd_addr_i  (issue_rd_addr_i),
      .hit_o      (sb_hit[r])
    );
  end

  logic young_v, mem_in_flight, drained;
  always_comb begin
    young_v       = 1'b0;
    mem_in_flight = 1'b0;
    for (int i = 0; i < depth_p; i++) begin
      if (i < depth_p - 1) young_v = young_v | dep_q[i].v;
      mem_in_flight = mem_in_flight | (dep_q[i].v & dep_q[i].mem);
    end
  end

  assign drained = credits_empty_i & ~mem_in_flight & mem_ready_i;

  bp_be_fence_state_e state_q;
  logic               drain_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_fence_idle;
      drain_q <= 1'b0;
    end else begin
      case (state_q)
        e_fence_idle: if (issue_fence_i && !drained) begin
          state_q <= e_fence_drain;
          drain_q <= 1'b1;
        end
        e_fence_drain: if (drained) begin
          state_q <= e_fence_idle;
          drain_q <= 1'b0;
        end
        default: begin
          state_q <= e_fence_idle;
          drain_q <= 1'b0;
        end
      endcase
    end
  end

  assign drain_o = drain_q;

  // Reset behaves like freeze for dispatch but reports no cause.
  logic [3:0] cause;
  always_comb begin
    cause                   = '0;
    cause[e_haz_data_bit]   = data_haz;
    cause[e_haz_sb_bit]     = |sb_hit;
    cause[e_haz_ctrl_bit]   = (issue_long_i & young_v)
                            | (issue_fence_i & ((state_q != e_fence_idle) | ~drained));
    cause[e_haz_struct_bit] = freeze_i | (issue_mem_i & ~mem_ready_i)
                            | (issue_long_i & ~long_ready_i);
    if (reset_i) cause = '0;
  end

  assign haz_cause_o   = cause;
  assign dispatch_ok_o = ~reset_i & ~|cause;

`ifdef BP_BE_HAZARD_TRACKER_PERF_EN
  logic [3:0][31:0] stall_cnt_q;
  logic             any_issue;

  assign any_issue = |issue_rs_v_i | issue_rd_v_i | issue_fence_i | issue_mem_i | issue_long_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (cause[b] && any_issue && (stall_cnt_q[b] != '1)) stall_cnt_q[b] <= stall_cnt_q[b] + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/bp_be_hazard_tracker.md
Name: bp_be_hazard_tracker

Overview:
Parametrised issue-stage hazard tracker for the BE checker, replacing the fixed 4-stage/2-regfile detector.
- Tracks in-flight writers in a depth_p-deep dependency shift register, and late (long-latency) writers in per-regfile scoreboards.
- Runs a fence-drain FSM.
- Produces a single dispatch permit plus a hazard-cause vector.
- Sits between the issue queue and the calculator.

Parameters:
depth_p, 4, number of tracked post-dispatch stages (stage 0 = dispatched last cycle)
num_pipes_p, 6, number of execution pipes; dispatch pipe select is one-hot
ready_stage_p, {1,1,2,3,3,5} packed 4b per pipe, cycles after dispatch until that pipe's result is forwardable (range 1..depth_p+1)
num_rf_p, 2, register files (rf 0 = integer, rf 0 addr 0 hardwired zero)
num_rs_p, 3, source operands per instruction
reg_addr_width_p, 5, register address width

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
freeze_i  in  1  config freeze; forces stall
issue_rs_v_i  in  num_rs_p  source valid
issue_rs_rf_i  in  num_rs_p*rf_sel_w  source regfile select (rf_sel_w = max(1, clog2(num_rf_p)))
issue_rs_addr_i  in  num_rs_p*reg_addr_width_p  source addresses
issue_rd_v_i / issue_rd_rf_i / issue_rd_addr_i  in  1 / rf_sel_w / reg_addr_width_p  destination
issue_fence_i, issue_mem_i, issue_long_i  in  1 each  instruction class
dispatch_v_i  in  1  instruction dispatched this cycle
dispatch_pipe_i  in  num_pipes_p  one-hot pipe
dispatch_rd_w_i, dispatch_late_i, dispatch_mem_i  in  1 each
dispatch_rd_rf_i / dispatch_rd_addr_i  in  rf_sel_w / reg_addr_width_p
clear_v_i  in  num_rf_p  late writeback per regfile
clear_addr_i  in  num_rf_p*reg_addr_width_p
credits_empty_i, mem_ready_i, long_ready_i  in  1 each
dispatch_ok_o  out  1  issue may dispatch
haz_cause_o  out  4  {struct, control, scoreboard, data}
drain_o  out  1  fence FSM in DRAIN

Behaviour:
- Reset is asynchronous, active-high.
  - Shift register entries, scoreboards and FSM clear; FSM enters IDLE.
  - Outputs: dispatch_ok_o = 0 while reset_i is high (freeze-equivalent), haz_cause_o = 0, drain_o = 0.
- Shift register:
  - Each cycle, stage 0 <= {dispatch_v_i, pipe, rd_w, rf, rd, mem} when dispatch_v_i, else 0.
  - Stage i <= stage i-1.
  - The oldest entry falls off.
- Data hazard:
  - Source s matches stage i when: stage valid & rd_w & rf equal & addr equal & i+1 < ready_stage_p[pipe].
  - A source with rf 0 and addr 0 never matches.
- Scoreboard:
  - One bit per register per rf.
  - Set on dispatch_v_i & dispatch_late_i & rd_w.
  - Clear on clear_v_i[rf].
  - Same-cycle set and clear of the same register: set wins.
  - Scoreboard hazard = any valid source hits a set bit (RAW), or issue_rd_v_i hits a set bit (WAW); r0 of rf 0 excluded.
  - The lookup uses registered state only; a clear is visible the cycle after it.
- Control hazard:
  - issue_long_i with any valid stage in 0..depth_p-2.
  - issue_fence_i while FSM != IDLE or not drained.
- Struct hazard: freeze_i | (issue_mem_i & ~mem_ready_i) | (issue_long_i & ~long_ready_i).
- Output: dispatch_ok_o = ~|haz_cause_o, combinational from the issue inputs and registered state.
- Fence FSM:
  - IDLE -> DRAIN when issue_fence_i and (~credits_empty_i | any stage mem | ~mem_ready_i).
  - DRAIN -> IDLE when credits_empty_i & no mem stage & mem_ready_i.
  - The fence dispatches in the cycle after the return to IDLE.
  - drain_o = (state == DRAIN).
- Illegal inputs (undefined):
  - dispatch_v_i while dispatch_ok_o = 0.
  - Non-one-hot dispatch_pipe_i.

Optional Feature:
BP_BE_HAZARD_TRACKER_PERF_EN
- Present: adds output stall_cnt_o, 4x32b packed, one saturating counter per haz_cause bit.
  - A counter increments on each cycle that bit is set while any issue_*_v/class input is high.
  - Counters are asynchronously reset and hold at 0xFFFFFFFF.
- Absent: port and counters are omitted; no other behavioural change.

Decomposition:
- Package bp_be_pkg gains:
  - bp_be_haz_dep_entry_s (v, pipe, rd_w, rf, rd, mem).
  - bp_be_haz_cause_e bit indices.
  - The default ready_stage packing constant.
- Sub-module bp_be_hazard_scoreboard: one regfile's bit vector with num_rs_p read ports plus rd port. Instantiated num_rf_p times via generate.

Test Plan:
1. Dispatch pipe 5 (ready 5) writing int x7; next cycles issue add rs1 = x7 -> dispatch_ok_o = 0 for 4 cycles, 1 on the 5th, haz_cause_o = 4'b0001 while stalled.
2. Dispatch pipe 0 (ready 1) writing x7, then issue with rs1 = x7 -> dispatch_ok_o = 1 immediately. Same sequence with rd = x0 on pipe 5 -> no stall.
3. Late-load to fp f3; issue fadd f3 -> stall, cause 4'b0010. clear_v_i[1] with addr 3 in cycle N -> dispatch_ok_o = 1 at N+1. Simultaneous set/clear of f3 -> bit stays set.
4. issue_fence_i with credits_empty_i = 0 -> drain_o = 1. Raise credits_empty_i at cycle N with mem_ready_i = 1 -> drain_o = 0 at N+1, dispatch_ok_o = 1 at N+1.
5. Assert reset_i asynchronously mid-DRAIN with scoreboard x9 set -> drain_o = 0 and scoreboard empty immediately. After release, issue rs1 = x9 -> dispatch_ok_o = 1.
6. With PERF_EN: freeze_i held 10 cycles with issue_mem_i = 1 -> struct counter = 10, other counters = 0.
